universal_register: RTL and testbench



---
 rtl/universal_register_pkg.sv | 28 ++
 rtl/universal_register_next.sv | 70 +++++++
 rtl/universal_register.sv | 80 ++++++++
 tb/tb_universal_register.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/universal_register_pkg.sv
`default_nettype none
// ============================================================================
// Module      : universal_register_pkg
// Description : Operation encoding shared by the universal register and its
//               next-state logic.
// Revision    : 1.0 - initial release
// ============================================================================
package universal_register_pkg;

  // Operation select field carried on the op port
  typedef logic [2:0] op_t;

  localparam op_t OP_HOLD = 3'b000;
  localparam op_t OP_LOAD = 3'b001;
  localparam op_t OP_SHL  = 3'b010;
  localparam op_t OP_SHR  = 3'b011;
  localparam op_t OP_ROL  = 3'b100;
  localparam op_t OP_ROR  = 3'b101;
  localparam op_t OP_INC  = 3'b110;
  localparam op_t OP_DEC  = 3'b111;

  // True for the two counting ops, the only ones that can raise wrap
  function automatic logic is_arith(input op_t op);
    return (op == OP_INC) || (op == OP_DEC);
  endfunction

endpackage : universal_register_pkg
`default_nettype wire

// File: rtl/universal_register_next.sv
`default_nettype none
// ============================================================================
// Module      : universal_register_next
// Description : Combinational next-value and carry/shift-out computation for
//               the universal register. Unknown op values fall back to hold.
// Revision    : 1.0 - initial release
// ============================================================================
module universal_register_next
  import universal_register_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] i,
  input  op_t              op,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] a_next,
  output logic             co_next
);

  // Arithmetic is done one bit wider so the carry / borrow lands in the MSB
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
  assign w_diff = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};

  // Select the result of the requested operation
  always_comb begin
    a_next  = a;
    co_next = 1'b0;
    case (op)
      OP_LOAD: begin
        a_next  = i;
        co_next = 1'b0;
      end
      OP_SHL: begin
        a_next  = {a[WIDTH-2:0], sin_l};
        co_next = a[WIDTH-1];
      end
      OP_SHR: begin
        a_next  = {sin_r, a[WIDTH-1:1]};
        co_next = a[0];
      end
      OP_ROL: begin
        a_next  = {a[WIDTH-2:0], a[WIDTH-1]};
        co_next = a[WIDTH-1];
      end
      OP_ROR: begin
        a_next  = {a[0], a[WIDTH-1:1]};
        co_next = a[0];
      end
      OP_INC: begin
        a_next  = w_sum[WIDTH-1:0];
        co_next = w_sum[WIDTH];
      end
      OP_DEC: begin
        a_next  = w_diff[WIDTH-1:0];
        co_next = w_diff[WIDTH];
      end
      default: begin
        a_next  = a;
        co_next = 1'b0;
      end
    endcase
  end

endmodule : universal_register_next
`default_nettype wire

// File: rtl/universal_register.sv
`default_nettype none
// ============================================================================
// Module      : universal_register
// Description : WIDTH-bit register with hold, load, shift, rotate, increment
//               and decrement, a registered carry/shift-out flag and a sticky
//               wrap flag. Synchronous clear beats enable, enable beats op.
// Revision    : 1.0 - initial release
// ============================================================================
module universal_register
  import universal_register_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  op_t              op,
  input  logic [WIDTH-1:0] I,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] A,
  output logic             co,
  output logic             wrap,
  output logic             zero
);

  logic [WIDTH-1:0] r_a;
  logic             r_co;
  logic             r_wrap;
  logic [WIDTH-1:0] w_a_next;
  logic             w_co_next;
  logic             w_co_upd;
  logic             w_wrap_set;

  universal_register_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .a       (r_a),
    .i       (I),
    .op      (op),
    .sin_l   (sin_l),
    .sin_r   (sin_r),
    .a_next  (w_a_next),
    .co_next (w_co_next)
  );

  // HOLD keeps the previous carry; every other op rewrites it
  assign w_co_upd   = (op != OP_HOLD);
  assign w_wrap_set = is_arith(op) && w_co_next;

  // State flops: clear overrides enable, enable gates the selected op
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a    <= RST_VAL;
      r_co   <= 1'b0;
      r_wrap <= 1'b0;
    end else if (clr) begin
      r_a    <= RST_VAL;
      r_co   <= 1'b0;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_a <= w_a_next;
      if (w_co_upd) begin
        r_co <= w_co_next;
      end
      if (w_wrap_set) begin
        r_wrap <= 1'b1;
      end
    end
  end

  assign A    = r_a;
  assign co   = r_co;
  assign wrap = r_wrap;
  assign zero = (r_a == '0);

endmodule : universal_register
`default_nettype wire

// File: tb/tb_universal_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_universal_register
// Description : Directed self-checking bench for universal_register (WIDTH=4).
//               A second instance with RST_VAL=4'b1010 covers the clear value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_register;
  import universal_register_pkg::*;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       clr;
  op_t        op;
  logic [3:0] I;
  logic       sin_l;
  logic       sin_r;
  logic [3:0] A;
  logic       co;
  logic       wrap;
  logic       zero;
  logic [3:0] a2;
  logic       co2;
  logic       wrap2;
  logic       zero2;

  int checks;
  int failures;

  universal_register #(
    .WIDTH   (4),
    .RST_VAL (4'b0000)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .en    (en),
    .clr   (clr),
    .op    (op),
    .I     (I),
    .sin_l (sin_l),
    .sin_r (sin_r),
    .A     (A),
    .co    (co),
    .wrap  (wrap),
    .zero  (zero)
  );

  universal_register #(
    .WIDTH   (4),
    .RST_VAL (4'b1010)
  ) dut_rv (
    .clk   (clk),
    .rstn  (rstn),
    .en    (en),
    .clr   (clr),
    .op    (op),
    .I     (I),
    .sin_l (sin_l),
    .sin_r (sin_r),
    .A     (a2),
    .co    (co2),
    .wrap  (wrap2),
    .zero  (zero2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One active edge, then settle 1ns before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input op_t o,
                       input logic [3:0] d, input logic sl, input logic sr);
    en = e; clr = c; op = o; I = d; sin_l = sl; sin_r = sr;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, OP_LOAD, 4'b0111, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, OP_DEC, 4'b0000, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({A, co, wrap} !== {4'b0000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_async: got A=%b co=%b wrap=%b, want A=0000 co=0 wrap=0", A, co, wrap);
    end
    checks++;
    if (zero !== 1'b1) begin
      failures++;
      $display("FAIL reset_zero: got %b, want 1", zero);
    end
    drive(1'b0, 1'b0, OP_HOLD, 4'b0000, 1'b0, 1'b0);
    #3 rstn = 1'b1;
  endtask

  task automatic test_clear();
    drive(1'b1, 1'b0, OP_LOAD, 4'b0011, 1'b0, 1'b0);
    tick();
    checks++;
    if (a2 !== 4'b0011) begin
      failures++;
      $display("FAIL clear_preload: got %b, want 0011", a2);
    end
    drive(1'b0, 1'b1, OP_HOLD, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if (a2 !== 4'b1010 || co2 !== 1'b0 || wrap2 !== 1'b0) begin
      failures++;
      $display("FAIL clear_rstval: got A=%b co=%b wrap=%b, want A=1010 co=0 wrap=0", a2, co2, wrap2);
    end
    checks++;
    if (A !== 4'b0000) begin
      failures++;
      $display("FAIL clear_rst0: got %b, want 0000", A);
    end
    clr = 1'b0;
  endtask

  task automatic test_load_hold();
    drive(1'b1, 1'b0, OP_LOAD, 4'b1011, 1'b0, 1'b0);
    tick();
    checks++;
    if ({A, co, zero} !== {4'b1011, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL load: got A=%b co=%b zero=%b, want A=1011 co=0 zero=0", A, co, zero);
    end
    drive(1'b0, 1'b0, OP_LOAD, 4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (A !== 4'b1011) begin
        failures++;
        $display("FAIL en_hold[%0d]: got %b, want 1011", k, A);
      end
    end
  endtask

  task automatic test_shift_rotate();
    op_t        ops [4] = '{OP_SHL, OP_SHR, OP_ROL, OP_ROR};
    logic       sls [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic       srs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] exa [4] = '{4'b0110, 4'b1011, 4'b0111, 4'b1011};
    logic       exc [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, ops[k], 4'b0000, sls[k], srs[k]);
      tick();
      checks++;
      if (A !== exa[k] || co !== exc[k]) begin
        failures++;
        $display("FAIL shift_rot[%0d]: got A=%b co=%b, want A=%b co=%b", k, A, co, exa[k], exc[k]);
      end
    end
    // SHL with sin_l=1 from 1011 -> 0111, co=1
    drive(1'b1, 1'b0, OP_SHL, 4'b0000, 1'b1, 1'b0);
    tick();
    checks++;
    if (A !== 4'b0111 || co !== 1'b1) begin
      failures++;
      $display("FAIL shl_sin1: got A=%b co=%b, want A=0111 co=1", A, co);
    end
  endtask

  task automatic test_inc_wrap();
    drive(1'b1, 1'b0, OP_LOAD, 4'b1110, 1'b0, 1'b0);
    tick();
    op = OP_INC;
    tick();
    checks++;
    if ({A, co, wrap} !== {4'b1111, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL inc1: got A=%b co=%b wrap=%b, want A=1111 co=0 wrap=0", A, co, wrap);
    end
    tick();
    checks++;
    if ({A, co, wrap, zero} !== {4'b0000, 1'b1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL inc_wrap: got A=%b co=%b wrap=%b zero=%b, want A=0000 co=1 wrap=1 zero=1", A, co, wrap, zero);
    end
    op = OP_HOLD;
    tick();
    checks++;
    if ({A, co, wrap} !== {4'b0000, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL hold_co: got A=%b co=%b wrap=%b, want A=0000 co=1 wrap=1", A, co, wrap);
    end
    op = OP_INC;
    tick();
    checks++;
    if ({A, co, wrap} !== {4'b0001, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL inc_after: got A=%b co=%b wrap=%b, want A=0001 co=0 wrap=1", A, co, wrap);
    end
  endtask

  task automatic test_dec_borrow();
    drive(1'b1, 1'b1, OP_HOLD, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if ({A, co, wrap} !== {4'b0000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL clr_wrap: got A=%b co=%b wrap=%b, want A=0000 co=0 wrap=0", A, co, wrap);
    end
    drive(1'b1, 1'b0, OP_DEC, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if ({A, co, wrap} !== {4'b1111, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL dec_borrow: got A=%b co=%b wrap=%b, want A=1111 co=1 wrap=1", A, co, wrap);
    end
    drive(1'b1, 1'b1, OP_HOLD, 4'b0000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, OP_LOAD, 4'b0001, 1'b0, 1'b0);
    tick();
    op = OP_DEC;
    tick();
    checks++;
    if ({A, co, wrap, zero} !== {4'b0000, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL dec_to_zero: got A=%b co=%b wrap=%b zero=%b, want A=0000 co=0 wrap=0 zero=1", A, co, wrap, zero);
    end
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b0, OP_LOAD, 4'b1100, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, OP_LOAD, 4'b0101, 1'b0, 1'b0);
    tick();
    checks++;
    if (A !== 4'b0000) begin
      failures++;
      $display("FAIL clr_over_load: got %b, want 0000", A);
    end
    drive(1'b0, 1'b0, OP_INC, 4'b0000, 1'b0, 1'b0);
    tick();
    checks++;
    if (A !== 4'b0000 || co !== 1'b0) begin
      failures++;
      $display("FAIL en0_inc: got A=%b co=%b, want A=0000 co=0", A, co);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b0, OP_INC, 4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (A !== 4'b0010) begin
      failures++;
      $display("FAIL inc_seq: got %b, want 0010", A);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (A !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset: got %b, want 0000", A);
    end
    #4 rstn = 1'b1;
    tick();
    checks++;
    if (A !== 4'b0001 || co !== 1'b0) begin
      failures++;
      $display("FAIL inc_post_reset: got A=%b co=%b, want A=0001 co=0", A, co);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    drive(1'b0, 1'b0, OP_HOLD, 4'b0000, 1'b0, 1'b0);
    #12 rstn = 1'b1;
    checks++;
    if ({A, co, wrap, a2} !== {4'b0000, 1'b0, 1'b0, 4'b1010}) begin
      failures++;
      $display("FAIL power_on: got A=%b co=%b wrap=%b A2=%b, want 0000 0 0 1010", A, co, wrap, a2);
    end
    test_reset();
    test_clear();
    test_load_hold();
    test_shift_rotate();
    test_inc_wrap();
    test_dec_borrow();
    test_priority();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_universal_register
`default_nettype wire
